ram_wr_burst_arbiter: RTL and testbench

//  Shares the single write port of the 8x16 dual-port async RAM between two requesters in the wr_clk domain.

---
 rtl/ram_wr_burst_arbiter_if.sv | 40 ++++
 rtl/ram_wr_burst_arbiter.sv | 98 +++++++++
 tb/tb_ram_wr_burst_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_wr_burst_arbiter_if.sv
// rtl/ram_wr_burst_arbiter_if.sv - requester handshakes and RAM write-port bundle for the burst arbiter
interface ram_wr_burst_arbiter_if #(
    parameter int RAM_WIDTH = 16,
    parameter int ADDR_SIZE = 3
);
    logic                 req0;
    logic [ADDR_SIZE-1:0] base0;
    logic [ADDR_SIZE-1:0] len0;
    logic [RAM_WIDTH-1:0] data0;
    logic                 ack0;
    logic                 done0;

    logic                 req1;
    logic [ADDR_SIZE-1:0] base1;
    logic [ADDR_SIZE-1:0] len1;
    logic [RAM_WIDTH-1:0] data1;
    logic                 ack1;
    logic                 done1;

    logic                 ram_we;
    logic [ADDR_SIZE-1:0] ram_wr_addr;
    logic [RAM_WIDTH-1:0] ram_data;
    logic                 busy;

    // Requester / observer side
    modport master (
        output req0, base0, len0, data0,
        output req1, base1, len1, data1,
        input  ack0, done0, ack1, done1,
        input  ram_we, ram_wr_addr, ram_data, busy
    );

    // Arbiter side
    modport slave (
        input  req0, base0, len0, data0,
        input  req1, base1, len1, data1,
        output ack0, done0, ack1, done1,
        output ram_we, ram_wr_addr, ram_data, busy
    );
endinterface

// File: rtl/ram_wr_burst_arbiter.sv
// rtl/ram_wr_burst_arbiter.sv - round-robin burst arbiter for the shared RAM write port
module ram_wr_burst_arbiter #(
    parameter int RAM_WIDTH = 16,
    parameter int RAM_DEPTH = 8,
    parameter int ADDR_SIZE = 3
) (
    input logic                    wr_clk,
    input logic                    clr,
    ram_wr_burst_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BURST0 = 2'd1,
        BURST1 = 2'd2
    } state_t;

    localparam logic [ADDR_SIZE:0] DEPTH_W = (ADDR_SIZE+1)'(RAM_DEPTH);

    state_t               state;
    logic [ADDR_SIZE-1:0] cnt;
    logic [ADDR_SIZE-1:0] base_q;
    logic [ADDR_SIZE-1:0] len_q;
    logic                 rr_last;

    logic [ADDR_SIZE:0]   addr_sum;
    logic [ADDR_SIZE-1:0] addr_next;
    logic [RAM_WIDTH-1:0] beat_data;
    logic                 last_beat;

    // Beat address wraps modulo the RAM depth; sum is one bit wider so the wrap is explicit
    assign addr_sum  = {1'b0, base_q} + {1'b0, cnt};
    assign addr_next = (addr_sum >= DEPTH_W) ? ADDR_SIZE'(addr_sum - DEPTH_W)
                                             : addr_sum[ADDR_SIZE-1:0];
    assign beat_data = (state == BURST1) ? bus.data1 : bus.data0;
    assign last_beat = (cnt == len_q);

    // Acks tell the owning requester its current word is taken at the next edge
    assign bus.ack0 = (state == BURST0);
    assign bus.ack1 = (state == BURST1);
    assign bus.busy = (state != IDLE);

    // Arbitration, burst sequencing and registered RAM write port
    always_ff @(posedge wr_clk or posedge clr) begin
        if (clr) begin
            state           <= IDLE;
            cnt             <= '0;
            base_q          <= '0;
            len_q           <= '0;
            rr_last         <= 1'b1;
            bus.ram_we      <= 1'b0;
            bus.ram_wr_addr <= '0;
            bus.ram_data    <= '0;
            bus.done0       <= 1'b0;
            bus.done1       <= 1'b0;
        end else begin
            bus.done0 <= 1'b0;
            bus.done1 <= 1'b0;
            case (state)
                IDLE: begin
                    bus.ram_we <= 1'b0;
                    // On a tie the requester that was not granted last wins
                    if (bus.req0 && (!bus.req1 || rr_last)) begin
                        state   <= BURST0;
                        base_q  <= bus.base0;
                        len_q   <= bus.len0;
                        cnt     <= '0;
                        rr_last <= 1'b0;
                    end else if (bus.req1) begin
                        state   <= BURST1;
                        base_q  <= bus.base1;
                        len_q   <= bus.len1;
                        cnt     <= '0;
                        rr_last <= 1'b1;
                    end
                end
                BURST0, BURST1: begin
                    bus.ram_we      <= 1'b1;
                    bus.ram_wr_addr <= addr_next;
                    bus.ram_data    <= beat_data;
                    cnt             <= cnt + 1'b1;
                    // Always pass through IDLE so the other side gets a chance to win
                    if (last_beat) begin
                        state <= IDLE;
                        if (state == BURST0) begin
                            bus.done0 <= 1'b1;
                        end else begin
                            bus.done1 <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    bus.ram_we <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_wr_burst_arbiter.sv
// tb/tb_ram_wr_burst_arbiter.sv - randomized self-checking bench for the RAM write burst arbiter
module tb_ram_wr_burst_arbiter;
    localparam int MAXC = 128;

    typedef struct packed {
        logic [2:0]       base;
        logic [2:0]       len;
        logic [7:0][15:0] d;
    } burst_t;

    logic wr_clk = 1'b0;
    logic clr;
    int   errors = 0;
    int   checks = 0;

    ram_wr_burst_arbiter_if #(.RAM_WIDTH(16), .ADDR_SIZE(3)) bus ();

    ram_wr_burst_arbiter #(.RAM_WIDTH(16), .RAM_DEPTH(8), .ADDR_SIZE(3)) dut (
        .wr_clk (wr_clk),
        .clr    (clr),
        .bus    (bus)
    );

    always #5 wr_clk = ~wr_clk;

    // The RAM that the arbiter writes; cleared by the shared clr
    logic [15:0] ram_mem [8];
    always_ff @(posedge wr_clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < 8; i++) ram_mem[i] <= '0;
        end else if (bus.ram_we) begin
            ram_mem[bus.ram_wr_addr] <= bus.ram_data;
        end
    end

    burst_t      q0[$];
    burst_t      q1[$];
    int          idx[2];
    int          beat[2];
    logic        active[2];
    logic        rr_model;
    logic [15:0] exp_mem[8];

    logic        e_we[MAXC];
    logic [2:0]  e_addr[MAXC];
    logic [15:0] e_data[MAXC];
    logic        e_ack0[MAXC];
    logic        e_ack1[MAXC];
    logic        e_busy[MAXC];
    logic        e_done0[MAXC];
    logic        e_done1[MAXC];
    int          n_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic burst_t make_burst(input logic [2:0] base, input logic [2:0] len);
        burst_t b;
        b.base = base;
        b.len  = len;
        for (int k = 0; k < 8; k++) b.d[k] = 16'($urandom);
        return b;
    endfunction

    // Timeline model: each grant takes one IDLE cycle, then len+1 ack cycles; writes trail acks by one
    task automatic build_model();
        int     c, i0, i1, w;
        logic   rr;
        burst_t b;
        logic [2:0] a;
        for (int k = 0; k < MAXC; k++) begin
            e_we[k] = 0; e_addr[k] = 0; e_data[k] = 0; e_ack0[k] = 0; e_ack1[k] = 0;
            e_busy[k] = 0; e_done0[k] = 0; e_done1[k] = 0;
        end
        c = 0; i0 = 0; i1 = 0; rr = rr_model;
        while (i0 < q0.size() || i1 < q1.size()) begin
            if (i0 < q0.size() && i1 < q1.size()) w = rr ? 0 : 1;
            else w = (i0 < q0.size()) ? 0 : 1;
            rr = (w == 1);
            if (w == 0) begin b = q0[i0]; i0++; end
            else begin b = q1[i1]; i1++; end
            for (int k = 0; k <= int'(b.len); k++) begin
                if (w == 0) e_ack0[c+1+k] = 1; else e_ack1[c+1+k] = 1;
                e_busy[c+1+k] = 1;
                a = 3'((int'(b.base) + k) % 8);
                e_we[c+2+k]   = 1;
                e_addr[c+2+k] = a;
                e_data[c+2+k] = b.d[k];
                exp_mem[a]    = b.d[k];
            end
            if (w == 0) e_done0[c+int'(b.len)+2] = 1; else e_done1[c+int'(b.len)+2] = 1;
            c = c + int'(b.len) + 2;
        end
        n_cyc    = c + 1;
        rr_model = rr;
    endtask

    // Requester behaviour: hold req with beat 0 until acked, then advance data per ack
    task automatic drive(input int i, input logic a);
        int     n;
        burst_t b;
        logic   rq;
        logic [2:0]  bs, ln;
        logic [15:0] dt;
        n = (i == 0) ? q0.size() : q1.size();
        b = '0;
        if (idx[i] < n) b = (i == 0) ? q0[idx[i]] : q1[idx[i]];
        if (a && idx[i] < n) begin
            active[i] = 1'b1;
            beat[i]++;
            if (beat[i] > int'(b.len)) begin
                idx[i]++; beat[i] = 0; active[i] = 1'b0;
                if (idx[i] < n) b = (i == 0) ? q0[idx[i]] : q1[idx[i]];
            end
        end
        if (idx[i] >= n) begin
            rq = 1'b0; bs = 3'($urandom); ln = 3'($urandom); dt = 16'($urandom);
        end else if (active[i]) begin
            rq = 1'($urandom); bs = 3'($urandom); ln = 3'($urandom); dt = b.d[beat[i]];
        end else begin
            rq = 1'b1; bs = b.base; ln = b.len; dt = b.d[0];
        end
        if (i == 0) begin bus.req0 = rq; bus.base0 = bs; bus.len0 = ln; bus.data0 = dt; end
        else begin bus.req1 = rq; bus.base1 = bs; bus.len1 = ln; bus.data1 = dt; end
    endtask

    task automatic reset_requesters();
        q0.delete(); q1.delete();
        for (int i = 0; i < 2; i++) begin idx[i] = 0; beat[i] = 0; active[i] = 1'b0; end
    endtask

    // Runs the queued bursts from an IDLE cycle, comparing every cycle and the RAM afterwards
    task automatic run_scenario(input string name);
        logic a0, a1;
        build_model();
        drive(0, 1'b0);
        drive(1, 1'b0);
        for (int c = 0; c <= n_cyc; c++) begin
            @(negedge wr_clk);
            check({name, ".wr"},
                  {12'd0, bus.ram_we, bus.ram_we ? bus.ram_wr_addr : 3'd0, bus.ram_we ? bus.ram_data : 16'd0},
                  {12'd0, e_we[c], e_we[c] ? e_addr[c] : 3'd0, e_we[c] ? e_data[c] : 16'd0});
            check({name, ".ctl"},
                  {27'd0, bus.ack0, bus.ack1, bus.busy, bus.done0, bus.done1},
                  {27'd0, e_ack0[c], e_ack1[c], e_busy[c], e_done0[c], e_done1[c]});
            a0 = bus.ack0; a1 = bus.ack1;
            @(posedge wr_clk); #1;
            drive(0, a0);
            drive(1, a1);
        end
        for (int k = 0; k < 8; k++) check({name, ".ram"}, {16'd0, ram_mem[k]}, {16'd0, exp_mem[k]});
        reset_requesters();
    endtask

    initial begin
        logic a0;
        burst_t b;
        clr = 1'b1;
        bus.req0 = 0; bus.base0 = 0; bus.len0 = 0; bus.data0 = 0;
        bus.req1 = 0; bus.base1 = 0; bus.len1 = 0; bus.data1 = 0;
        reset_requesters();
        rr_model = 1'b1;
        for (int k = 0; k < 8; k++) exp_mem[k] = '0;
        repeat (2) @(posedge wr_clk);
        @(negedge wr_clk);
        check("reset.wr", {12'd0, bus.ram_we, bus.ram_wr_addr, bus.ram_data}, 32'd0);
        check("reset.ctl", {27'd0, bus.ack0, bus.ack1, bus.busy, bus.done0, bus.done1}, 32'd0);
        @(posedge wr_clk); #1;
        clr = 1'b0;

        // Tie straight after reset: requester 0 first
        q0.push_back(make_burst(3'd2, 3'd1));
        q1.push_back(make_burst(3'd5, 3'd1));
        run_scenario("tie");

        // Wrapping burst with known data
        b = make_burst(3'd6, 3'd3);
        for (int k = 0; k < 4; k++) b.d[k] = 16'(16'h00A0 + k);
        q0.push_back(b);
        run_scenario("wrap");

        // Both held with single-beat bursts: grants alternate
        for (int k = 0; k < 3; k++) begin
            q0.push_back(make_burst(3'($urandom), 3'd0));
            q1.push_back(make_burst(3'($urandom), 3'd0));
        end
        run_scenario("fair");

        // Full-depth burst covering every address
        q1.push_back(make_burst(3'd0, 3'd7));
        run_scenario("full");

        for (int r = 0; r < 25; r++) begin
            int n0, n1;
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            for (int k = 0; k < n0; k++) q0.push_back(make_burst(3'($urandom), 3'($urandom)));
            for (int k = 0; k < n1; k++) q1.push_back(make_burst(3'($urandom), 3'($urandom)));
            run_scenario("rand");
        end

        // Make requester 1 the last winner, then clear in the middle of a 6-beat burst
        q1.push_back(make_burst(3'd1, 3'd0));
        run_scenario("pre_clr");
        q0.push_back(make_burst(3'd3, 3'd5));
        drive(0, 1'b0);
        drive(1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge wr_clk);
            a0 = bus.ack0;
            @(posedge wr_clk); #1;
            drive(0, a0);
        end
        check("clr.beat2_ack", {31'd0, bus.ack0}, 32'd1);
        #2;
        clr = 1'b1;
        #1;
        check("clr.now", {27'd0, bus.ram_we, bus.busy, bus.ack0, bus.done0, bus.done1}, 32'd0);
        @(posedge wr_clk); #1;
        check("clr.hold", {27'd0, bus.ram_we, bus.busy, bus.ack0, bus.done0, bus.done1}, 32'd0);
        reset_requesters();
        bus.req0 = 0; bus.req1 = 0;
        rr_model = 1'b1;
        for (int k = 0; k < 8; k++) exp_mem[k] = '0;
        clr = 1'b0;

        // After the clear requester 0 must win the tie again
        q0.push_back(make_burst(3'd4, 3'd2));
        q1.push_back(make_burst(3'd0, 3'd1));
        run_scenario("post_clr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
